fft_frame_feeder: RTL

//  Input framer directly upstream of the FFT serial-to-parallel shift register.
//  - Buffers a bursty complex sample stream (valid/ready) in an internal FIFO.
//  - Releases samples only as whole, gap-free frames of 2**POW beats, with valid_out held high for the whole frame.
//  - The downstream beat counter therefore always sees complete frames and never sees a partial frame.

---
 rtl/fft_frame_feeder_if.sv | 25 ++
 rtl/fft_frame_feeder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fft_frame_feeder_if.sv
// Stream interface for fft_frame_feeder: sample input handshake plus framed output.
// master = upstream/testbench side, slave = the feeder itself.
interface fft_frame_feeder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_r;
  logic signed [DATA_WIDTH-1:0] in_i;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] source_r;
  logic signed [DATA_WIDTH-1:0] source_i;
  logic                         sop;
  logic                         eop;

  modport master (
    output in_valid, in_r, in_i,
    input  in_ready, valid_out, source_r, source_i, sop, eop
  );

  modport slave (
    input  in_valid, in_r, in_i,
    output in_ready, valid_out, source_r, source_i, sop, eop
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers a bursty complex sample stream in a FIFO and releases
// it only as whole, gap-free frames of 2**POW beats.
// Optional feature macro: FFT_FEEDER_B2B_EN (back-to-back frames, skips the gap
// when a full next frame is already buffered).
module fft_frame_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int POW        = 3,
  parameter int FIFO_POW   = POW + 1,
  parameter int GAP_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  fft_frame_feeder_if.slave  bus
);
  localparam int N  = 1 << POW;
  localparam int D  = 1 << FIFO_POW;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [FIFO_POW:0] N_CNT     = (FIFO_POW+1)'(N);
  localparam logic [FIFO_POW:0] D_CNT     = (FIFO_POW+1)'(D);
  localparam logic [POW-1:0]    BEAT_LAST = '1;
  localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  logic signed [DATA_WIDTH-1:0] mem_r [0:D-1];
  logic signed [DATA_WIDTH-1:0] mem_i [0:D-1];
  logic [FIFO_POW-1:0]          wr_ptr, rd_ptr;
  logic [FIFO_POW:0]            cnt;

  state_t                       state;
  logic [POW-1:0]               beat;
  logic [GW-1:0]                gcnt;
  logic                         valid_q, sop_q, eop_q;
  logic signed [DATA_WIDTH-1:0] src_r_q, src_i_q;

  logic push, load;

  // in_ready only looks at registered occupancy, so a same-cycle pop never frees a full FIFO
  assign bus.in_ready = ~rst & (cnt < D_CNT);
  assign push         = bus.in_valid & bus.in_ready;

  // Decide whether this edge moves the FIFO head into the output register
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = (cnt >= N_CNT);
      BURST: begin
        if (beat != BEAT_LAST) load = 1'b1;
`ifdef FFT_FEEDER_B2B_EN
        else                   load = (cnt >= N_CNT);
`else
        else                   load = 1'b0;
`endif
      end
      default: load = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr] <= bus.in_r;
      mem_i[wr_ptr] <= bus.in_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap modulo D by width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Frame sequencer: IDLE waits for a full frame, BURST streams it, GAP idles the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      gcnt    <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      src_r_q <= '0;
      src_i_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            src_r_q <= mem_r[rd_ptr];
            src_i_q <= mem_i[rd_ptr];
            beat    <= '0;
            state   <= BURST;
          end
        end
        BURST: begin
          if (beat != BEAT_LAST) begin
            beat    <= beat + 1'b1;
            sop_q   <= 1'b0;
            eop_q   <= (beat == BEAT_LAST - 1'b1);
            src_r_q <= mem_r[rd_ptr];
            src_i_q <= mem_i[rd_ptr];
          end else if (load) begin
            // next frame already fully buffered: restart without a gap
            beat    <= '0;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
            src_r_q <= mem_r[rd_ptr];
            src_i_q <= mem_i[rd_ptr];
          end else begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            src_r_q <= '0;
            src_i_q <= '0;
            gcnt    <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gcnt == GAP_LAST) state <= IDLE;
          else                  gcnt  <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.sop       = sop_q;
  assign bus.eop       = eop_q;
  assign bus.source_r  = src_r_q;
  assign bus.source_i  = src_i_q;
endmodule
